yuv2rgb: RTL

Pipelined YUV-to-RGB colour-space converter for 24-bit pixels (BT.601 full-range, 8.8 fixed point). It is the inverse stage of the luma/RGB path: it sits after the YUV-domain processing blocks and before the display/output formatter. A valid/ready stream handshake on both sides supports back-pressure and bubble collapsing.

---
 rtl/yuv2rgb.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/yuv2rgb.sv
// yuv2rgb: pipelined BT.601 full-range YUV -> RGB converter, 8.8 fixed point.
//
// Ports:
//   clk_i    in   clock
//   rst_n_i  in   asynchronous active-low reset
//   valid_i  in   input pixel valid
//   ready_o  out  block can accept a pixel this cycle
//   data_i   in   {Y, U, V}, 8 bits each, unsigned
//   valid_o  out  output pixel valid
//   ready_i  in   downstream accepts the output pixel
//   data_o   out  {R, G, B}, 8 bits each, unsigned
//
// Parameter OUT_REG: 1 registers the outputs (3-cycle latency),
//                    0 drives them combinationally from stage 2 (2-cycle latency).
// Macro YUV2RGB_SAT_EN: defined -> channels clamp to 0..255;
//                       undefined -> channels wrap to the low 8 bits.
module yuv2rgb #(
  parameter bit OUT_REG = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [23:0] data_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [23:0] data_o
);

  // Stage 1: luma plus centred chroma
  logic              s1_valid;
  logic        [7:0] s1_y;
  logic signed [8:0] s1_u;
  logic signed [8:0] s1_v;

  // Stage 2: scaled luma and chroma products
  logic               s2_valid;
  logic signed [17:0] s2_y;
  logic signed [17:0] s2_rv;
  logic signed [17:0] s2_gu;
  logic signed [17:0] s2_gv;
  logic signed [17:0] s2_bu;

  // A stage can take new content when empty or when its content leaves this cycle.
  logic s2_free;
  logic s3_free;

  logic signed [17:0] sum_r;
  logic signed [17:0] sum_g;
  logic signed [17:0] sum_b;
  logic        [23:0] data_c;

  assign s2_free = !s2_valid || s3_free;
  assign ready_o = !s1_valid || s2_free;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_valid <= 1'b0;
      s1_y     <= '0;
      s1_u     <= '0;
      s1_v     <= '0;
    end else if (ready_o) begin
      s1_valid <= valid_i;
      if (valid_i) begin
        s1_y <= data_i[23:16];
        s1_u <= $signed({1'b0, data_i[15:8]}) - 9'sd128;
        s1_v <= $signed({1'b0, data_i[7:0]}) - 9'sd128;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s2_valid <= 1'b0;
      s2_y     <= '0;
      s2_rv    <= '0;
      s2_gu    <= '0;
      s2_gv    <= '0;
      s2_bu    <= '0;
    end else if (s2_free) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_y  <= $signed({2'b00, s1_y, 8'h00});
        s2_rv <= 18'sd359 * s1_v;
        s2_gu <= 18'sd88  * s1_u;
        s2_gv <= 18'sd183 * s1_v;
        s2_bu <= 18'sd454 * s1_u;
      end
    end
  end

`ifdef YUV2RGB_SAT_EN
  function automatic logic [7:0] clamp8(input logic signed [9:0] q);
    if (q[9])      return 8'h00;
    else if (q[8]) return 8'hFF;
    else           return q[7:0];
  endfunction
`endif

  // Bits [17:8] of each sum are the floor-shifted value; the fraction is dropped.
  always_comb begin
    sum_r = s2_y + s2_rv + 18'sd128;
    sum_g = s2_y - s2_gu - s2_gv + 18'sd128;
    sum_b = s2_y + s2_bu + 18'sd128;
`ifdef YUV2RGB_SAT_EN
    data_c = {clamp8(sum_r[17:8]), clamp8(sum_g[17:8]), clamp8(sum_b[17:8])};
`else
    data_c = {sum_r[15:8], sum_g[15:8], sum_b[15:8]};
`endif
  end

  // Fraction bits (and, in wrap mode, the upper bits) are intentionally discarded.
  logic unused_sum_bits;
  assign unused_sum_bits = ^{sum_r[17:16], sum_r[7:0], sum_g[17:16], sum_g[7:0],
                             sum_b[17:16], sum_b[7:0]};

  if (OUT_REG) begin : g_out_reg
    logic        s3_valid;
    logic [23:0] s3_data;

    assign s3_free = !s3_valid || ready_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        s3_valid <= 1'b0;
        s3_data  <= '0;
      end else if (s3_free) begin
        s3_valid <= s2_valid;
        if (s2_valid) s3_data <= data_c;
      end
    end

    assign valid_o = s3_valid;
    assign data_o  = s3_data;
  end else begin : g_out_comb
    // Stage 2 registers face the output directly, so they free up only on transfer.
    assign s3_free = ready_i;
    assign valid_o = s2_valid;
    assign data_o  = data_c;
  end

endmodule
